cmp_seq_n: RTL
==============

// Module: cmp_seq_n
// PURPOSE
//  Parametrised multi-cycle magnitude/equality comparator, successor to the 4-bit
//  equality unit. Compares WIDTH-bit operands SLICE bits per cycle, MSB first,
//  with early termination, and reports eq/gt/lt in unsigned or signed mode.
//  Sits between operand registers and control logic behind a start/busy/done handshake.
// PARAMETERS
//  WIDTH   16  operand width in bits; must be a multiple of SLICE
//  SLICE    4  bits compared per clock; 1 <= SLICE <= WIDTH
//  CNT_W    8  width of match counter (used only with CMP_MATCH_CNT_EN)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous reset, active-low
//  start      in   1       request; sampled only when busy=0
//  a          in   WIDTH   operand A, captured on accepted start
//  b          in   WIDTH   operand B, captured on accepted start
//  is_signed  in   1       1: two's-complement compare; captured with operands
//  busy       out  1       comparison in progress
//  done       out  1       one-cycle pulse: results valid/updated
//  aeqb       out  1       A == B
//  agtb       out  1       A > B
//  altb       out  1       A < B
//  clr_cnt    in   1       sync clear of match_cnt (macro only)
//  match_cnt  out  CNT_W   saturating count of equal results (macro only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): FSM->IDLE; busy, done, aeqb, agtb, altb = 0; shift regs,
//    slice counter = 0; match_cnt = 0. Reset mid-RUN aborts; no done issued.
//  - FSM IDLE: start=1 at edge -> capture a,b,is_signed; if is_signed invert MSB of
//    both copies (offset binary, then unsigned compare); slice idx=0; -> RUN, busy=1.
//  - FSM RUN: each edge compare top SLICE bits of the A/B shift regs.
//    slice_a>slice_b: agtb=1, others 0, done=1, -> IDLE.
//    slice_a<slice_b: altb=1, others 0, done=1, -> IDLE.
//    equal, idx==WIDTH/SLICE-1: aeqb=1, others 0, done=1, -> IDLE.
//    equal otherwise: shift both left by SLICE, idx++, stay RUN.
//  - Latency: done high k edges after start edge, k = 1-based index of first
//    differing slice, or WIDTH/SLICE if equal. busy falls in the same edge done rises.
//  - start while busy=1: ignored, operands not re-captured.
//  - start in the cycle done=1: accepted (FSM already IDLE); back-to-back throughput.
//  - Results one-hot after first done; held until next done (not cleared on start).
//  - a/b may change freely after capture; no effect on current compare.
//  - WIDTH==SLICE: single-cycle compare, done one edge after start.
// CONFIGURATION
//  CMP_MATCH_CNT_EN defined: clr_cnt/match_cnt ports exist; match_cnt += 1 on each
//   done with aeqb=1, saturates at 2**CNT_W-1; clr_cnt=1 clears it at the edge and
//   has priority over a coincident increment.
//  Not defined: ports and counter absent; all other behaviour identical.
// TESTING
//  1 W16/S4 unsigned a=0x1234 b=0x1234 -> done 4 edges after start, aeqb=1.
//  2 W16/S4 a=0x8000 b=0x7FFF is_signed=0 -> done after 1 edge, agtb=1; is_signed=1 -> altb=1.
//  3 W16/S4 a=0x1235 b=0x1234 -> done after 4 edges, agtb=1; then a=0xFFFF b=0x0001 signed -> altb=0 agtb=0? no: -1<1 -> altb=1.
//  4 W4/S1 a=0001 b=0000 -> agtb at edge 4; a=0101 b=0011 -> agtb at edge 2; a=b=0000 -> aeqb at edge 4.
//  5 start pulsed during busy with new operands -> ignored, original result; rst_n=0 mid-RUN
//    -> busy,done,aeqb,agtb,altb=0 immediately, no done after release.
//  6 CMP_MATCH_CNT_EN, CNT_W=8: 3 equal + 1 unequal -> match_cnt=3; 300 equal -> 255;
//    clr_cnt with coincident equal done -> 0.

Source files
------------

// File: rtl/cmp_seq_n_if.sv
// Handshake/operand bundle for cmp_seq_n.
// Optional match counter signals exist only when CMP_MATCH_CNT_EN is defined.
interface cmp_seq_n_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             aeqb;
  logic             agtb;
  logic             altb;
`ifdef CMP_MATCH_CNT_EN
  logic             clr_cnt;
  logic [CNT_W-1:0] match_cnt;
`endif

  // Requester side: drives operands, observes results.
  modport master (
    output start, a, b, is_signed,
`ifdef CMP_MATCH_CNT_EN
    output clr_cnt,
    input  match_cnt,
`endif
    input  busy, done, aeqb, agtb, altb
  );

  // Comparator side.
  modport slave (
    input  start, a, b, is_signed,
`ifdef CMP_MATCH_CNT_EN
    input  clr_cnt,
    output match_cnt,
`endif
    output busy, done, aeqb, agtb, altb
  );
endinterface

// File: rtl/cmp_seq_n.sv
// Multi-cycle MSB-first magnitude/equality comparator with early termination.
// Compares SLICE bits per clock; signed mode flips operand MSBs (offset binary)
// so one unsigned datapath serves both modes.
// Optional feature macro: CMP_MATCH_CNT_EN (saturating count of equal results).
module cmp_seq_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  cmp_seq_n_if.slave   bus
);

  localparam int unsigned NumSlices = WIDTH / SLICE;
  localparam int unsigned IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             done_q, done_d;
  logic             aeqb_q, aeqb_d;
  logic             agtb_q, agtb_d;
  logic             altb_q, altb_d;
  logic [WIDTH-1:0] a_cap, b_cap;
  logic [SLICE-1:0] slice_a, slice_b;
  logic             eq_done;

  assign slice_a = a_sh_q[WIDTH-1 -: SLICE];
  assign slice_b = b_sh_q[WIDTH-1 -: SLICE];

  // Operand capture with MSB flip in signed mode.
  always_comb begin
    a_cap = bus.a;
    b_cap = bus.b;
    a_cap[WIDTH-1] = bus.a[WIDTH-1] ^ bus.is_signed;
    b_cap[WIDTH-1] = bus.b[WIDTH-1] ^ bus.is_signed;
  end

  // Next-state: accept in idle, one slice compare per cycle in run.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    aeqb_d  = aeqb_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;
    eq_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d  = a_cap;
          b_sh_d  = b_cap;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (slice_a > slice_b) begin
          {aeqb_d, agtb_d, altb_d} = 3'b010;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (slice_a < slice_b) begin
          {aeqb_d, agtb_d, altb_d} = 3'b001;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (idx_q == IdxW'(NumSlices - 1)) begin
          {aeqb_d, agtb_d, altb_d} = 3'b100;
          done_d  = 1'b1;
          eq_done = 1'b1;
          state_d = StIdle;
        end else begin
          a_sh_d = a_sh_q << SLICE;
          b_sh_d = b_sh_q << SLICE;
          idx_d  = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      aeqb_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      aeqb_q  <= aeqb_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.aeqb = aeqb_q;
  assign bus.agtb = agtb_q;
  assign bus.altb = altb_q;

`ifdef CMP_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  // Saturating equal-result counter; clear wins over a coincident increment.
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (bus.clr_cnt) begin
      match_cnt_d = '0;
    end else if (eq_done && (match_cnt_q != {CNT_W{1'b1}})) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt_q <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
    end
  end

  assign bus.match_cnt = match_cnt_q;
`endif

endmodule
